usb_pkt_rx: RTL

//  Packet decoder directly downstream of the UTMI receive side. Consumes the UTMI rx byte stream
//  (data/rx_valid/rx_active/rx_error); checks PID, splits token/data/handshake packets, checks
//  CRC5/CRC16 and streams payload bytes (CRC stripped) to the SIE. Ends each packet with a status pulse.

---
 rtl/usb_pkt_pkg.sv | 50 +++++
 rtl/usb_crc.sv | 47 ++++
 rtl/usb_pkt_rx.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_pkt_pkg.sv
// -----------------------------------------------------------------------------
// usb_pkt_pkg
// Shared definitions for the USB packet receive and transmit paths:
//   - usb_pid_t     : 4-bit PID codes (PRE and ERR share 4'hC)
//   - PID_CLASS_*   : packet class encoded in PID[1:0]
//   - CRC5_* / CRC16_*: polynomials, initial values and good-packet residuals
//                       for the LSB-first shift-left CRC form used on the wire
//   - USB_MAX_PAYLOAD : largest data payload in bytes (CRC16 excluded)
//   - pid_check()     : PID byte self-check (upper nibble is the complement)
// -----------------------------------------------------------------------------
package usb_pkt_pkg;

  typedef enum logic [3:0] {
    PID_RSVD    = 4'h0,
    PID_OUT     = 4'h1,
    PID_ACK     = 4'h2,
    PID_DATA0   = 4'h3,
    PID_PING    = 4'h4,
    PID_SOF     = 4'h5,
    PID_NYET    = 4'h6,
    PID_DATA2   = 4'h7,
    PID_SPLIT   = 4'h8,
    PID_IN      = 4'h9,
    PID_NAK     = 4'hA,
    PID_DATA1   = 4'hB,
    PID_PRE_ERR = 4'hC,
    PID_SETUP   = 4'hD,
    PID_STALL   = 4'hE,
    PID_MDATA   = 4'hF
  } usb_pid_t;

  localparam logic [1:0] PID_CLASS_SPECIAL = 2'b00;
  localparam logic [1:0] PID_CLASS_TOKEN   = 2'b01;
  localparam logic [1:0] PID_CLASS_HSK     = 2'b10;
  localparam logic [1:0] PID_CLASS_DATA    = 2'b11;

  localparam logic [4:0]  CRC5_POLY      = 5'h05;
  localparam logic [4:0]  CRC5_INIT      = 5'h1F;
  localparam logic [4:0]  CRC5_RESIDUAL  = 5'h0C;
  localparam logic [15:0] CRC16_POLY     = 16'h8005;
  localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

  localparam int USB_MAX_PAYLOAD = 1023;

  function automatic logic pid_check(input logic [7:0] b);
    return b[7:4] == ~b[3:0];
  endfunction

endpackage

// File: rtl/usb_crc.sv
// -----------------------------------------------------------------------------
// usb_crc
// Byte-wide CRC accumulator, bits consumed LSB first, register shifted left
// with feedback from its MSB. Used for both the CRC5 and the CRC16 checks.
// Ports:
//   clk, rst : clock, asynchronous active-high reset (register -> INIT)
//   clr      : synchronous reload of INIT (has priority over en)
//   en       : fold data into the CRC this cycle
//   data     : byte to fold in
//   crc      : current CRC register
// -----------------------------------------------------------------------------
module usb_crc #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] POLY  = 16'h8005,
  parameter logic [WIDTH-1:0] INIT  = 16'hFFFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [7:0]       data,
  output logic [WIDTH-1:0] crc
);

  function automatic logic [WIDTH-1:0] next_crc(input logic [WIDTH-1:0] c,
                                               input logic [7:0]       d);
    logic [WIDTH-1:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[WIDTH-1] ^ d[i])
        r = {r[WIDTH-2:0], 1'b0} ^ POLY;
      else
        r = {r[WIDTH-2:0], 1'b0};
    end
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      crc <= INIT;
    else if (clr)
      crc <= INIT;
    else if (en)
      crc <= next_crc(crc, data);
  end

endmodule

// File: rtl/usb_pkt_rx.sv
// -----------------------------------------------------------------------------
// usb_pkt_rx
// Packet decoder behind the UTMI receive interface. Checks the PID, splits
// token / data / handshake packets, checks CRC5 / CRC16, streams data payload
// (CRC bytes stripped) and ends every packet with a one-cycle status pulse.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   rx_data    : UTMI byte; accepted when rx_valid && rx_active
//   rx_valid   : byte strobe
//   rx_active  : packet in progress; its falling edge ends the packet
//   rx_error   : UTMI receive error, sticky for the packet
//   pid        : PID[3:0] of current / last packet
//   tok_addr   : token address      (updated at end of a clean token)
//   tok_endp   : token endpoint     (updated at end of a clean token)
//   sof_frame  : SOF frame number   (updated at end of a clean SOF)
//   pd_data    : payload byte, qualified by pd_valid
//   pd_valid   : one pulse per payload byte (tentative until pkt_ok)
//   data_len   : payload length of last data packet
//   pkt_done   : one-cycle end-of-packet pulse
//   pkt_ok     : pkt_done with no error flags
//   pkt_err    : {rx_err, len_err, crc_err, pid_err}, valid with pkt_done
// -----------------------------------------------------------------------------
module usb_pkt_rx
  import usb_pkt_pkg::*;
#(
  parameter int MAX_PAYLOAD = USB_MAX_PAYLOAD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_active,
  input  logic        rx_error,
  output logic [3:0]  pid,
  output logic [6:0]  tok_addr,
  output logic [3:0]  tok_endp,
  output logic [10:0] sof_frame,
  output logic [7:0]  pd_data,
  output logic        pd_valid,
  output logic [10:0] data_len,
  output logic        pkt_done,
  output logic        pkt_ok,
  output logic [3:0]  pkt_err
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_PID   = 3'd1;
  localparam logic [2:0] ST_TOKEN = 3'd2;
  localparam logic [2:0] ST_DATA  = 3'd3;
  localparam logic [2:0] ST_HSK   = 3'd4;
  localparam logic [2:0] ST_DRAIN = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;

  // Byte count (payload + 2 CRC bytes) above which the payload is too long.
  localparam logic [10:0] MAX_CNT = 11'(MAX_PAYLOAD + 2);

  logic [2:0]  state_reg;
  logic        rx_active_prev_reg;
  logic [10:0] byte_cnt_reg;
  logic [7:0]  tok_b1_reg;
  logic [2:0]  tok_b2_reg;
  logic [7:0]  dly0_reg;
  logic [7:0]  dly1_reg;
  logic [3:0]  pid_reg;
  logic [6:0]  tok_addr_reg;
  logic [3:0]  tok_endp_reg;
  logic [10:0] sof_frame_reg;
  logic [7:0]  pd_data_reg;
  logic        pd_valid_reg;
  logic [10:0] data_len_reg;
  logic        rx_err_reg;
  logic        len_err_reg;
  logic        crc_err_reg;
  logic        pid_err_reg;

  logic        accept;
  logic        fall;
  logic        in_pkt;
  logic        pkt_end;
  logic        len_fin;
  logic        crc_fin;
  logic [3:0]  err_fin;
  logic [4:0]  crc5;
  logic [15:0] crc16;

  assign accept  = rx_valid && rx_active;
  assign fall    = rx_active_prev_reg && !rx_active;
  assign in_pkt  = (state_reg == ST_TOKEN) || (state_reg == ST_DATA) ||
                   (state_reg == ST_HSK)   || (state_reg == ST_DRAIN);
  assign pkt_end = fall && in_pkt;

  // CRC registers sit at their initial value between packets; the PID byte
  // is never folded in because enables are gated by the body states.
  usb_crc #(.WIDTH(5), .POLY(CRC5_POLY), .INIT(CRC5_INIT)) u_crc5 (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_reg == ST_IDLE),
    .en   (accept && (state_reg == ST_TOKEN)),
    .data (rx_data),
    .crc  (crc5)
  );

  usb_crc #(.WIDTH(16), .POLY(CRC16_POLY), .INIT(CRC16_INIT)) u_crc16 (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_reg == ST_IDLE),
    .en   (accept && (state_reg == ST_DATA)),
    .data (rx_data),
    .crc  (crc16)
  );

  // Final error flags as seen at the end of the packet: length and CRC
  // checks can only be judged once the whole packet has been received.
  always_comb begin
    len_fin = len_err_reg;
    crc_fin = crc_err_reg;
    case (state_reg)
      ST_TOKEN: begin
        len_fin = len_err_reg || (byte_cnt_reg != 11'd2);
        crc_fin = crc_err_reg || (crc5 != CRC5_RESIDUAL);
      end
      ST_DATA: begin
        len_fin = len_err_reg || (byte_cnt_reg < 11'd2);
        crc_fin = crc_err_reg || (crc16 != CRC16_RESIDUAL);
      end
      default: ;
    endcase
    err_fin = {rx_err_reg, len_fin, crc_fin, pid_err_reg};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg          <= ST_IDLE;
      rx_active_prev_reg <= 1'b0;
      byte_cnt_reg       <= '0;
      tok_b1_reg         <= '0;
      tok_b2_reg         <= '0;
      dly0_reg           <= '0;
      dly1_reg           <= '0;
      pid_reg            <= '0;
      tok_addr_reg       <= '0;
      tok_endp_reg       <= '0;
      sof_frame_reg      <= '0;
      pd_data_reg        <= '0;
      pd_valid_reg       <= 1'b0;
      data_len_reg       <= '0;
      rx_err_reg         <= 1'b0;
      len_err_reg        <= 1'b0;
      crc_err_reg        <= 1'b0;
      pid_err_reg        <= 1'b0;
    end else begin
      rx_active_prev_reg <= rx_active;
      pd_valid_reg       <= 1'b0;

      if ((state_reg != ST_IDLE) && (state_reg != ST_DONE) && rx_active && rx_error)
        rx_err_reg <= 1'b1;

      if (accept && (byte_cnt_reg != 11'h7FF) && in_pkt)
        byte_cnt_reg <= byte_cnt_reg + 11'd1;

      case (state_reg)
        ST_IDLE: begin
          if (rx_active) begin
            state_reg    <= ST_PID;
            byte_cnt_reg <= '0;
            rx_err_reg   <= 1'b0;
            len_err_reg  <= 1'b0;
            crc_err_reg  <= 1'b0;
            pid_err_reg  <= 1'b0;
          end
        end
        ST_PID: begin
          if (fall) begin
            state_reg <= ST_IDLE;
          end else if (accept) begin
            pid_reg <= rx_data[3:0];
            if (!pid_check(rx_data)) begin
              pid_err_reg <= 1'b1;
              state_reg   <= ST_DRAIN;
            end else begin
              case (rx_data[1:0])
                PID_CLASS_TOKEN: state_reg <= ST_TOKEN;
                PID_CLASS_DATA:  state_reg <= ST_DATA;
                PID_CLASS_HSK:   state_reg <= ST_HSK;
                default: begin
                  if (rx_data[3:0] == PID_PING)
                    state_reg <= ST_TOKEN;
                  else if (rx_data[3:0] == PID_PRE_ERR)
                    state_reg <= ST_HSK;
                  else begin
                    pid_err_reg <= 1'b1;
                    state_reg   <= ST_DRAIN;
                  end
                end
              endcase
            end
          end
        end
        ST_TOKEN: begin
          if (accept) begin
            if (byte_cnt_reg == 11'd0) tok_b1_reg <= rx_data;
            if (byte_cnt_reg == 11'd1) tok_b2_reg <= rx_data[2:0];
          end
        end
        ST_DATA: begin
          // Two-byte delay line: a byte is only known to be payload once
          // two further bytes have arrived, so the CRC16 never leaks out.
          if (accept) begin
            dly0_reg <= rx_data;
            dly1_reg <= dly0_reg;
            if ((byte_cnt_reg >= 11'd2) && !len_err_reg) begin
              if (byte_cnt_reg >= MAX_CNT) begin
                len_err_reg <= 1'b1;
              end else begin
                pd_data_reg  <= dly1_reg;
                pd_valid_reg <= 1'b1;
              end
            end
          end
        end
        ST_HSK: begin
          if (accept) len_err_reg <= 1'b1;
        end
        ST_DONE: state_reg <= ST_IDLE;
        default: ;
      endcase

      // End of packet: latch final flags and publish fields so they are
      // stable during the pkt_done cycle.
      if (pkt_end) begin
        state_reg   <= ST_DONE;
        len_err_reg <= len_fin;
        crc_err_reg <= crc_fin;
        if ((state_reg == ST_TOKEN) && (err_fin == 4'b0000)) begin
          tok_addr_reg <= tok_b1_reg[6:0];
          tok_endp_reg <= {tok_b2_reg, tok_b1_reg[7]};
          if (pid_reg == PID_SOF)
            sof_frame_reg <= {tok_b2_reg, tok_b1_reg};
        end
        if (state_reg == ST_DATA)
          data_len_reg <= (byte_cnt_reg < 11'd2) ? 11'd0 : byte_cnt_reg - 11'd2;
      end
    end
  end

  assign pid       = pid_reg;
  assign tok_addr  = tok_addr_reg;
  assign tok_endp  = tok_endp_reg;
  assign sof_frame = sof_frame_reg;
  assign pd_data   = pd_data_reg;
  assign pd_valid  = pd_valid_reg;
  assign data_len  = data_len_reg;
  assign pkt_done  = (state_reg == ST_DONE);
  assign pkt_err   = pkt_done ? {rx_err_reg, len_err_reg, crc_err_reg, pid_err_reg} : 4'b0000;
  assign pkt_ok    = pkt_done && ({rx_err_reg, len_err_reg, crc_err_reg, pid_err_reg} == 4'b0000);

endmodule
